// File: rtl/bpred_pkg.sv
// Shared definitions for the branch-predictor slice.
//   - 2-bit saturating counter encodings (strong/weak not-taken/taken)
//   - default table index width and global history width
package bpred_pkg;

   localparam int IDX_W_DEFAULT = 6;
   localparam int GHR_W_DEFAULT = 6;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/bpred_ctr_next.sv
// Next-state function of a 2-bit saturating direction counter.
// Ports:
//   ctr_i   : current counter value
//   taken_i : resolved outcome (1 = step toward strong-taken)
//   ctr_o   : counter after one saturating step
module bpred_ctr_next
   import bpred_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor.
// A flop-based table of 2-bit counters is indexed by PC[IDX_W+1:2] XOR the
// global history. The prediction is registered (1-cycle latency). Updates
// come back from execute with the index handed out at prediction time and
// also shift the (non-speculative) global history.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   lk_valid, lk_pc    : lookup request and fetch PC
//   pred_valid/taken/idx : registered prediction and the index used
//   upd_valid/idx/taken  : resolved-branch update
//   ghr_out            : current global history register
module gshare_predictor
   import bpred_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEFAULT,
   parameter int GHR_W = GHR_W_DEFAULT
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             lk_valid,
   input  logic [31:0]      lk_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   output logic [GHR_W-1:0] ghr_out
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]       tbl_q [DEPTH];
   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic [IDX_W-1:0] pred_idx_q,   pred_idx_d;

   logic [IDX_W-1:0] lk_idx;
   logic [1:0]       upd_ctr;
   logic [1:0]       upd_ctr_nxt;
   logic [1:0]       lk_ctr;

   // PC bits outside the index field do not participate in the hash.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};

   // History is zero-extended to the index width before hashing.
   assign lk_idx  = lk_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign upd_ctr = tbl_q[upd_idx];

   // One next-counter instance: its result is written back on update and
   // also forwarded to a same-cycle lookup hitting the same entry.
   bpred_ctr_next u_ctr_next (
      .ctr_i   (upd_ctr),
      .taken_i (upd_taken),
      .ctr_o   (upd_ctr_nxt)
   );

   always_comb begin
      lk_ctr = tbl_q[lk_idx];
      if (upd_valid && (upd_idx == lk_idx)) lk_ctr = upd_ctr_nxt;
   end

   always_comb begin
      ghr_d        = ghr_q;
      pred_valid_d = lk_valid;
      pred_taken_d = pred_taken_q;
      pred_idx_d   = pred_idx_q;
      if (upd_valid) ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
      if (lk_valid) begin
         pred_taken_d = lk_ctr[1];
         pred_idx_d   = lk_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_SNT;
      end else if (upd_valid) begin
         tbl_q[upd_idx] <= upd_ctr_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_idx_q   <= '0;
      end else begin
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_idx_q   <= pred_idx_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_idx   = pred_idx_q;
   assign ghr_out    = ghr_q;

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter IDX_W, default 6, sets the table index width; the table holds 2^IDX_W entries.
REQ-002 Parameter GHR_W, default 6, sets the global history width; GHR_W SHALL be <= IDX_W.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 lk_valid  in  1  lookup request from fetch this cycle.
REQ-006 lk_pc  in  32  fetch PC of the branch being predicted.
REQ-007 pred_valid  out  1  prediction available; registered.
REQ-008 pred_taken  out  1  predicted direction; registered.
REQ-009 pred_idx  out  IDX_W  table index used; fetch returns it with the update.
REQ-010 upd_valid  in  1  resolved-branch update from execute.
REQ-011 upd_idx  in  IDX_W  index returned from the earlier pred_idx.
REQ-012 upd_taken  in  1  actual branch outcome.
REQ-013 ghr_out  out  GHR_W  current global history; debug/observability.

Function
REQ-014 Table entries SHALL be 2-bit saturating counters with encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 Lookup index SHALL be lk_pc[IDX_W+1:2] XOR {zero-extended ghr}; PC bits [1:0] are ignored.
REQ-016 Prediction latency SHALL be 1 cycle: a lookup in cycle N drives pred_valid=1, pred_taken=counter[1] and pred_idx in cycle N+1.
REQ-017 pred_valid SHALL be 0 in any cycle that follows a cycle with lk_valid=0; pred_taken and pred_idx then hold their last values.
REQ-018 An update SHALL move counter[upd_idx] one step toward upd_taken: taken increments, not-taken decrements.
REQ-019 Counters SHALL saturate: taken at 11 stays 11, and not-taken at 00 stays 00; there is no wrap-around.
REQ-020 An update SHALL shift the GHR left by one, inserting upd_taken at bit 0 and discarding the MSB; the history is non-speculative.
REQ-021 If a lookup and an update occur in the same cycle, the lookup SHALL use the pre-update GHR for its index.
REQ-022 If a lookup and an update occur in the same cycle and the lookup index equals upd_idx, the prediction SHALL use the post-update counter value (bypass).
REQ-023 Back-to-back updates to the same index SHALL each take effect, so no update is lost.
REQ-024 ghr_out SHALL equal the registered GHR with no added latency.

Reset
REQ-025 While reset is asserted, all counters SHALL be 00, the GHR SHALL be 0, pred_valid SHALL be 0, pred_taken SHALL be 0 and pred_idx SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL clear state immediately, without waiting for clk.
REQ-027 A lookup or update pending in the reset cycle SHALL be discarded.
REQ-028 The first lookup after reset deassertion SHALL predict not-taken.

Structure
REQ-029 A shared package bpred_pkg SHALL hold the counter encoding constants CTR_SNT, CTR_WNT, CTR_WT and CTR_ST, plus the default IDX_W and GHR_W.
REQ-030 A combinational sub-module bpred_ctr_next SHALL compute the next counter value from (current counter, taken); the same instance serves the update path and the bypass path.
REQ-031 The table SHALL be implemented in flops with asynchronous reset; no SRAM macro is used.

Verification
REQ-032 Reset, then lookup lk_pc=0x0000_0040 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0x10.
REQ-033 Four updates of idx 0x10 with taken=1 -> counter sequence 01, 10, 11, 11; a lookup landing on idx 0x10 predicts taken from the second update onward.
REQ-034 Counter at 11, then updates with taken=0 three times -> 10, 01, 00, and a fourth not-taken update leaves 00.
REQ-035 Updates with taken pattern 1,0,1 from reset -> ghr_out=0b000101; lookup lk_pc=0x40 -> pred_idx=0x10 XOR 0x05=0x15.
REQ-036 Same-cycle lookup and update hitting idx 0x15, with counter=01 and upd_taken=1 -> pred_taken=1 the next cycle.
REQ-037 Reset pulse asserted between clock edges while pred_valid=1 -> pred_valid=0 and ghr_out=0 immediately, and all counters read 00 afterwards.
